// File: rtl/pkt_af_pkg.sv
// rtl/pkt_af_pkg.sv - shared types and constants for the almost-full paced receive buffer
package pkt_af_pkg;

    // Width of the saturating drop and error counters
    localparam int CNT_W = 32;

    // Write-side packet framing state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    // Framing flags carried in every storage word, between data and empty
    typedef struct packed {
        logic sop;
        logic eop;
    } pkt_ctrl_t;

endpackage

// File: rtl/pkt_buf_ram.sv
// rtl/pkt_buf_ram.sv - simple dual-port RAM, one write port, one registered read port
module pkt_buf_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;

    // Write port and one-cycle-latency read port; no reset so the array maps to block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pkt_af_rx_buffer.sv
// rtl/pkt_af_rx_buffer.sv - packet receive FIFO with almost_full pacing, commit/rewind and drop counting
module pkt_af_rx_buffer
    import pkt_af_pkg::*;
#(
    parameter int DWIDTH    = 512,
    parameter int EWIDTH    = 6,
    parameter int DEPTH     = 512,
    parameter int AF_MARGIN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [EWIDTH-1:0] in_empty,
    input  logic              in_valid,
    output logic              almost_full,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [EWIDTH-1:0] out_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W  = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        pkt_ctrl_t         ctrl;
        logic [EWIDTH-1:0] empty;
    } word_t;

    localparam int WW = $bits(word_t);

    // Write side: wr_ptr runs ahead speculatively, commit_ptr marks the last complete packet
    wr_state_t        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             almost_full_q, almost_full_d;

    // Read side: rd_ptr frees storage only when the consumer takes a word; fetch_ptr feeds the prefetch
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    fetch_ptr_q, fetch_ptr_d;
    logic             rd_pend_q, rd_pend_d;
    logic             out_valid_q, out_valid_d;
    word_t            out_word_q, out_word_d;
    logic             skid_valid_q, skid_valid_d;
    word_t            skid_word_q, skid_word_d;

    logic             do_write;
    logic             err_inc;
    logic             drop_inc;
    logic             ram_we;
    logic [PW-1:0]    wbase;
    logic [PW-1:0]    used;
    word_t            wr_word;
    word_t            rd_word;
    logic [WW-1:0]    ram_rdata;
    logic             pop;
    logic             fetch;
    logic [1:0]       occ;
    logic [1:0]       occ_after;

    assign wr_word = {in_data, in_sop, in_eop, in_empty};
    assign rd_word = word_t'(ram_rdata);
    assign used    = wr_ptr_q - rd_ptr_q;

    // Framing FSM: any sop restarts at commit_ptr; a write into a full buffer abandons the packet
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        do_write     = 1'b0;
        err_inc      = 1'b0;
        drop_inc     = 1'b0;
        ram_we       = 1'b0;
        wbase        = wr_ptr_q;
        if (in_valid) begin
            if (in_sop) begin
                do_write = 1'b1;
                wbase    = commit_ptr_q;
                err_inc  = (state_q != IDLE);
            end else begin
                case (state_q)
                    IDLE:    err_inc = 1'b1;
                    PKT:     do_write = 1'b1;
                    default: if (in_eop) state_d = IDLE;
                endcase
            end
            if (do_write) begin
                if (wbase - rd_ptr_q == DEPTH_W) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_inc = 1'b1;
                    state_d  = in_eop ? IDLE : DROP;
                end else begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wbase + PW'(1);
                    if (in_eop) begin
                        commit_ptr_d = wbase + PW'(1);
                        state_d      = IDLE;
                    end else begin
                        state_d = PKT;
                    end
                end
            end
        end
        err_cnt_d     = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        drop_cnt_d    = (drop_inc && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
        almost_full_d = (used >= AF_LEVEL);
    end

    // Write-side registers; almost_full sits high through reset so upstream holds off
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            err_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            almost_full_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            err_cnt_q     <= err_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Prefetch: output register plus skid; reads issue only while the pair can absorb them
    always_comb begin
        pop       = out_valid_q & out_ready;
        occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
        occ_after = occ - {1'b0, pop};
        fetch     = (fetch_ptr_q != commit_ptr_q) && (occ_after < 2'd2);

        rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fetch_ptr_d  = fetch ? fetch_ptr_q + PW'(1) : fetch_ptr_q;
        rd_pend_d    = fetch;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;

        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = skid_word_q;
                skid_valid_d = rd_pend_q;
                if (rd_pend_q) begin
                    skid_word_d = rd_word;
                end
            end else begin
                out_valid_d = rd_pend_q;
                if (rd_pend_q) begin
                    out_word_d = rd_word;
                end
            end
        end else if (rd_pend_q) begin
            skid_valid_d = 1'b1;
            skid_word_d  = rd_word;
        end
    end

    // Read-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            rd_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_pend_q    <= rd_pend_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
        end
    end

    pkt_buf_ram #(
        .WIDTH (WW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wbase[AW-1:0]),
        .wdata (wr_word),
        .re    (fetch),
        .raddr (fetch_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign almost_full = almost_full_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_word_q.data;
    assign out_sop     = out_word_q.ctrl.sop;
    assign out_eop     = out_word_q.ctrl.eop;
    assign out_empty   = out_word_q.empty;
    assign drop_cnt    = drop_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_pkt_af_rx_buffer.sv
// tb/tb_pkt_af_rx_buffer.sv - scoreboard bench for pkt_af_rx_buffer with a packet-level reference model
module tb_pkt_af_rx_buffer;

    localparam int DW    = 32;
    localparam int EW    = 3;
    localparam int DEPTH = 64;
    localparam int AFM   = 16;

    typedef logic [DW+EW+1:0] tword_t;  // {data, sop, eop, empty}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic          in_valid = 1'b0;
    logic          almost_full;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   drop_cnt;
    logic [31:0]   err_cnt;

    always #5 clk = ~clk;

    pkt_af_rx_buffer #(
        .DWIDTH    (DW),
        .EWIDTH    (EW),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AFM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_empty    (in_empty),
        .in_valid    (in_valid),
        .almost_full (almost_full),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_empty   (out_empty),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drop_cnt    (drop_cnt),
        .err_cnt     (err_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_out  = 0;

    // Reference model: committed words awaiting output, the open packet, and framing mode
    tword_t exp_q[$];
    tword_t part_q[$];
    int     mode   = 0;  // 0 idle, 1 in packet, 2 dropping
    int     m_err  = 0;
    int     m_drop = 0;

    tword_t cur;
    tword_t prev_w;
    bit     stalled = 1'b0;

    assign cur = {out_data, out_sop, out_eop, out_empty};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Packet-level rules: a packet becomes visible only once its eop lands with room for every word
    task automatic model_word(input logic sop, input logic eop, input logic [DW-1:0] d, input logic [EW-1:0] e);
        bit wr = 1'b0;
        if (sop) begin
            if (mode != 0) m_err++;
            part_q.delete();
            wr = 1'b1;
        end else if (mode == 0) begin
            m_err++;
        end else if (mode == 1) begin
            wr = 1'b1;
        end else if (eop) begin
            mode = 0;
        end
        if (wr) begin
            if (exp_q.size() + part_q.size() == DEPTH) begin
                part_q.delete();
                m_drop++;
                mode = eop ? 0 : 2;
            end else begin
                part_q.push_back({d, sop, eop, e});
                if (eop) begin
                    foreach (part_q[i]) exp_q.push_back(part_q[i]);
                    part_q.delete();
                    mode = 0;
                end else begin
                    mode = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic sop, input logic eop, input logic [DW-1:0] d, input logic [EW-1:0] e);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        in_empty = e;
        model_word(sop, eop, d, e);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d, input logic [EW-1:0] e);
        drive_word(sop, eop, d, e);
        tick();
        idle_in();
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            send(i == 0, i == len - 1, $urandom, (i == len - 1) ? EW'($urandom) : EW'(0));
        end
    endtask

    task automatic drain(input string name);
        int i = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && i < 1000) begin
            tick();
            i++;
        end
        repeat (3) tick();
        chk({name, "_drain_time"}, 64'(i < 1000), 64'd1);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every transfer pops the scoreboard; a stalled word must hold until taken
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_word", 64'(cur), 64'(prev_w));
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("out_word", 64'(cur), 64'(exp_q.pop_front()));
            end
            stalled = out_valid && !out_ready;
            prev_w  = cur;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int lat;
        int n0;
        int sent;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_af", 64'(almost_full), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sop", 64'(out_sop), 64'd0);
        chk("rst_out_eop", 64'(out_eop), 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        chk("af_release_same_cycle", 64'(almost_full), 64'd1);
        tick();
        chk("af_release", 64'(almost_full), 64'd0);

        // Single-word packet latency into an empty buffer
        out_ready = 1'b1;
        t0 = cyc;
        send(1'b1, 1'b1, $urandom, EW'($urandom));
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("lat_single", 64'(lat), 64'd3);
        tick();
        drain("single");

        // 8-word packet: becomes visible three cycles after its eop
        n0 = n_out;
        t0 = cyc;
        send_pkt(8);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("lat_8word", 64'(lat), 64'd10);
        tick();
        drain("pkt8");
        chk("pkt8_words", 64'(n_out - n0), 64'd8);
        chk("pkt8_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("pkt8_err_cnt", 64'(err_cnt), 64'd0);

        // almost_full threshold at DEPTH - AF_MARGIN = 48
        out_ready = 1'b0;
        for (int i = 0; i < 47; i++) send(i == 0, 1'b0, $urandom, EW'(0));
        repeat (3) tick();
        chk("af_at_47", 64'(almost_full), 64'd0);
        send(1'b0, 1'b1, $urandom, EW'($urandom));
        tick();
        chk("af_at_48", 64'(almost_full), 64'd1);
        repeat (4) tick();
        chk("af_out_ready_word", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("af_read_lag1", 64'(almost_full), 64'd1);
        tick();
        chk("af_read_lag2", 64'(almost_full), 64'd0);
        drain("af");

        // Overflow: 60 words stored, then a 10-word packet that cannot fit
        out_ready = 1'b0;
        n0 = n_out;
        for (int p = 0; p < 6; p++) send_pkt(10);
        repeat (2) tick();
        chk("ovf_af", 64'(almost_full), 64'd1);
        send_pkt(10);
        tick();
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("ovf_err_cnt", 64'(err_cnt), 64'd0);
        drain("ovf");
        chk("ovf_words", 64'(n_out - n0), 64'd60);

        // sop in the middle of a packet abandons it
        out_ready = 1'b1;
        n0 = n_out;
        send(1'b1, 1'b0, $urandom, EW'(0));
        send(1'b0, 1'b0, $urandom, EW'(0));
        send(1'b1, 1'b0, $urandom, EW'(0));
        send(1'b0, 1'b1, $urandom, EW'($urandom));
        drain("midsop");
        chk("midsop_err_cnt", 64'(err_cnt), 64'd1);
        chk("midsop_words", 64'(n_out - n0), 64'd2);

        // Word without sop while idle is discarded
        n0 = n_out;
        send(1'b0, 1'b0, $urandom, EW'(0));
        repeat (5) tick();
        chk("nosop_out_valid", 64'(out_valid), 64'd0);
        chk("nosop_err_cnt", 64'(err_cnt), 64'd2);
        chk("nosop_err_model", 64'(err_cnt), 64'(m_err));
        drain("nosop");
        chk("nosop_words", 64'(n_out - n0), 64'd0);

        // Back-to-back single-word packets, random consumer, upstream paced by almost_full
        n0   = n_out;
        sent = 0;
        for (int c = 0; c < 600; c++) begin
            out_ready = (($urandom & 32'd1) != 0);
            if (!almost_full && (($urandom & 32'd3) != 0)) begin
                drive_word(1'b1, 1'b1, $urandom, EW'($urandom));
                sent++;
            end
            tick();
            idle_in();
        end
        drain("rand");
        chk("rand_words", 64'(n_out - n0), 64'(sent));
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("rand_err_cnt", 64'(err_cnt), 64'(m_err));

        // Reset mid-packet throws away stored and partial data
        out_ready = 1'b0;
        send_pkt(2);
        send(1'b1, 1'b0, $urandom, EW'(0));
        send(1'b0, 1'b0, $urandom, EW'(0));
        rst = 1'b1;
        exp_q.delete();
        part_q.delete();
        mode   = 0;
        m_err  = 0;
        m_drop = 0;
        repeat (2) tick();
        chk("mrst_af", 64'(almost_full), 64'd1);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick();
        n0 = n_out;
        out_ready = 1'b1;
        send(1'b1, 1'b1, $urandom, EW'($urandom));
        drain("mrst");
        chk("mrst_words", 64'(n_out - n0), 64'd1);
        chk("mrst_err_after", 64'(err_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
